// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush separate from back-pressure, and saturating stall counter.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   flush          synchronous kill of all held entries
//   in_valid       upstream presents in_data
//   in_ready       stage accepts in_data this cycle
//   in_data        upstream payload (DATA_W)
//   out_valid      out_data holds a real entry
//   out_ready      downstream consumes out_data this cycle
//   out_data       payload to downstream, NOP_DATA when out_valid=0
//   occupancy      held entries: 0, 1 or 2
//   stall_cnt      saturating count of out_valid & !out_ready cycles
//   stall_cnt_clr  synchronous clear of stall_cnt
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 172,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int unsigned       SKID     = 1,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = 2'(state_q);
  assign stall_cnt = cnt_q;

  // Skid mode: in_ready depends only on registered state; otherwise it
  // looks through to out_ready so a single register can stream.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != ST_FULL) & ~flush;
    end else begin : g_noskid
      assign in_ready = (~out_valid | out_ready) & ~flush;
    end
  endgenerate

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // State and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_DATA;
      skid_q  <= NOP_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, payload movement and stall counter.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_DATA;
      skid_d  = NOP_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
            main_d  = NOP_DATA;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_DATA;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_DATA;
          skid_d  = NOP_DATA;
        end
      endcase
    end

    // Clear wins over increment; flush blocks counting but does not clear.
    if (stall_cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: three instances
// (0: SKID=1 NOP=00 CNT_W=16, 1: SKID=0 NOP=A5, 2: SKID=1 NOP=3C CNT_W=2).
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] fl, iv, ordy, clr;
  logic [7:0] id [3];

  logic       ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;
  logic [7:0] od_a, od_b, od_c;
  logic [1:0] occ_a, occ_b, occ_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_err    = 0;

  pipe_stage_reg #(.DATA_W(8), .NOP_DATA(8'h00), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir_a),
    .in_data(id[0]), .out_valid(ov_a), .out_ready(ordy[0]), .out_data(od_a),
    .occupancy(occ_a), .stall_cnt(cnt_a), .stall_cnt_clr(clr[0]));

  pipe_stage_reg #(.DATA_W(8), .NOP_DATA(8'hA5), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir_b),
    .in_data(id[1]), .out_valid(ov_b), .out_ready(ordy[1]), .out_data(od_b),
    .occupancy(occ_b), .stall_cnt(cnt_b), .stall_cnt_clr(clr[1]));

  pipe_stage_reg #(.DATA_W(8), .NOP_DATA(8'h3C), .SKID(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir_c),
    .in_data(id[2]), .out_valid(ov_c), .out_ready(ordy[2]), .out_data(od_c),
    .occupancy(occ_c), .stall_cnt(cnt_c), .stall_cnt_clr(clr[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: a bounded FIFO per instance ----------
  logic [7:0] mbuf [3][2];
  int         msize [3];
  int         mcnt  [3];

  function automatic int skid_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic logic [7:0] nop_of(input int d);
    case (d)
      1:       return 8'hA5;
      2:       return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 2) ? 3 : 65535;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      msize[d] = 0;
      mcnt[d]  = 0;
    end
  endtask

  // Compare one instance against the model before the edge, then advance it.
  task automatic model_cycle(input int d);
    logic       e_ov, e_ir, cons, acc;
    logic [7:0] e_od;
    logic       a_ir, a_ov;
    logic [7:0] a_od;
    logic [1:0] a_occ;
    logic [15:0] a_cnt;
    case (d)
      0:       begin a_ir = ir_a; a_ov = ov_a; a_od = od_a; a_occ = occ_a; a_cnt = cnt_a; end
      1:       begin a_ir = ir_b; a_ov = ov_b; a_od = od_b; a_occ = occ_b; a_cnt = cnt_b; end
      default: begin a_ir = ir_c; a_ov = ov_c; a_od = od_c; a_occ = occ_c; a_cnt = 16'(cnt_c); end
    endcase
    e_ov = (msize[d] > 0);
    e_od = e_ov ? mbuf[d][0] : nop_of(d);
    if (skid_of(d) != 0) e_ir = !fl[d] && (msize[d] < 2);
    else                 e_ir = !fl[d] && ((msize[d] == 0) || ordy[d]);
    chk($sformatf("rand%0d_in_ready", d), 32'(a_ir), 32'(e_ir));
    chk($sformatf("rand%0d_out_valid", d), 32'(a_ov), 32'(e_ov));
    chk($sformatf("rand%0d_out_data", d), 32'(a_od), 32'(e_od));
    chk($sformatf("rand%0d_occupancy", d), 32'(a_occ), 32'(msize[d]));
    chk($sformatf("rand%0d_stall_cnt", d), 32'(a_cnt), 32'(mcnt[d]));
    if (clr[d]) mcnt[d] = 0;
    else if (e_ov && !ordy[d] && !fl[d] && mcnt[d] < cmax_of(d)) mcnt[d]++;
    if (fl[d]) begin
      msize[d] = 0;
    end else begin
      cons = e_ov & ordy[d];
      acc  = iv[d] & e_ir;
      if (cons) begin
        mbuf[d][0] = mbuf[d][1];
        msize[d]--;
      end
      if (acc) begin
        mbuf[d][msize[d]] = id[d];
        msize[d]++;
      end
    end
  endtask

  // ---------------- directed vectors for instance 0 ------------------------
  typedef struct {
    logic       fl, iv;
    logic [7:0] id;
    logic       ordy, clr;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_occ;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic f, input logic v, input logic [7:0] d,
                              input logic r, input logic c, input logic eir,
                              input logic eov, input logic [7:0] eod,
                              input logic [1:0] eocc, input logic [15:0] ecnt);
    vec_t t;
    t.fl = f; t.iv = v; t.id = d; t.ordy = r; t.clr = c;
    t.e_ir = eir; t.e_ov = eov; t.e_od = eod; t.e_occ = eocc; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic idle_all();
    fl = '0; iv = '0; ordy = '0; clr = '0;
    for (int d = 0; d < 3; d++) id[d] = 8'h00;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic prev_ov;

    // in_ready pre-edge; out_valid/out_data/occupancy/stall_cnt post-edge
    tbl[0]  = mk(0, 1, 8'h01, 1, 0, 1, 1, 8'h01, 1, 0);
    tbl[1]  = mk(0, 1, 8'h02, 1, 0, 1, 1, 8'h02, 1, 0);
    tbl[2]  = mk(0, 1, 8'h03, 1, 0, 1, 1, 8'h03, 1, 0);
    tbl[3]  = mk(0, 1, 8'h04, 1, 0, 1, 1, 8'h04, 1, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
    tbl[5]  = mk(0, 1, 8'h11, 0, 0, 1, 1, 8'h11, 1, 0);
    tbl[6]  = mk(0, 1, 8'h22, 0, 0, 1, 1, 8'h11, 2, 1);
    tbl[7]  = mk(0, 1, 8'h33, 0, 0, 0, 1, 8'h11, 2, 2);
    tbl[8]  = mk(0, 1, 8'h33, 1, 0, 0, 1, 8'h22, 1, 2);
    tbl[9]  = mk(0, 1, 8'h33, 1, 0, 1, 1, 8'h33, 1, 2);
    tbl[10] = mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 2);
    tbl[11] = mk(0, 1, 8'h66, 0, 0, 1, 1, 8'h66, 1, 2);
    tbl[12] = mk(0, 1, 8'h77, 0, 0, 1, 1, 8'h66, 2, 3);
    tbl[13] = mk(1, 1, 8'h55, 0, 0, 0, 0, 8'h00, 0, 3);
    tbl[14] = mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 3);
    tbl[15] = mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0);

    do_reset();
    chk("reset_out_valid", 32'(ov_a), 32'h0);
    chk("reset_out_data", 32'(od_a), 32'h00);
    chk("reset_occupancy", 32'(occ_a), 32'h0);
    chk("reset_in_ready", 32'(ir_a), 32'h1);
    chk("reset_out_data_b", 32'(od_b), 32'hA5);

    prev_ov = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fl[0] = tbl[i].fl; iv[0] = tbl[i].iv; id[0] = tbl[i].id;
      ordy[0] = tbl[i].ordy; clr[0] = tbl[i].clr;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(ir_a), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid_pre", i), 32'(ov_a), 32'(prev_ov));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(ov_a), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), 32'(od_a), 32'(tbl[i].e_od));
      chk($sformatf("vec%0d_occupancy", i), 32'(occ_a), 32'(tbl[i].e_occ));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(cnt_a), 32'(tbl[i].e_cnt));
      prev_ov = tbl[i].e_ov;
    end

    // Async reset mid-cycle while FULL.
    idle_all();
    iv[0] = 1'b1; id[0] = 8'h81;
    @(posedge clk); #1;
    id[0] = 8'h82;
    @(posedge clk); #1;
    chk("full_before_rst_occ", 32'(occ_a), 32'h2);
    iv[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(ov_a), 32'h0);
    chk("async_rst_out_data", 32'(od_a), 32'h00);
    chk("async_rst_occupancy", 32'(occ_a), 32'h0);
    chk("async_rst_stall_cnt", 32'(cnt_a), 32'h0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(ir_a), 32'h1);
    iv[0] = 1'b1; id[0] = 8'h90; ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_data", 32'(od_a), 32'h90);
    chk("post_rst_valid", 32'(ov_a), 32'h1);
    idle_all();

    // SKID=0: combinational in_ready from out_ready.
    iv[1] = 1'b1; id[1] = 8'h10;
    @(posedge clk); #1;
    chk("noskid_first_data", 32'(od_b), 32'h10);
    id[1] = 8'h20;
    #1;
    chk("noskid_blocked_in_ready", 32'(ir_b), 32'h0);
    ordy[1] = 1'b1;
    #1;
    chk("noskid_comb_in_ready", 32'(ir_b), 32'h1);
    @(posedge clk); #1;
    chk("noskid_pass_data", 32'(od_b), 32'h20);
    chk("noskid_pass_occ", 32'(occ_b), 32'h1);
    iv[1] = 1'b0;
    @(posedge clk); #1;
    chk("noskid_bubble_valid", 32'(ov_b), 32'h0);
    chk("noskid_bubble_data", 32'(od_b), 32'hA5);
    idle_all();

    // CNT_W=2: saturation and clear priority.
    iv[2] = 1'b1; id[2] = 8'h44;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_cnt_%0d", k), 32'(cnt_c), 32'((k > 3) ? 3 : k));
    end
    clr[2] = 1'b1;
    @(posedge clk); #1;
    chk("clr_over_stall", 32'(cnt_c), 32'h0);
    chk("clr_keeps_data", 32'(od_c), 32'h44);
    clr[2] = 1'b0; ordy[2] = 1'b1;
    @(posedge clk); #1;
    chk("drain_bubble_c", 32'(od_c), 32'h3C);

    // Randomized run against the FIFO model on all three instances.
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        fl[d]   = ($urandom_range(0, 15) == 0);
        iv[d]   = ($urandom_range(0, 3) != 0);
        ordy[d] = ($urandom_range(0, 2) != 0);
        clr[d]  = ($urandom_range(0, 31) == 0);
        id[d]   = 8'($urandom);
      end
      #1;
      for (int d = 0; d < 3; d++) model_cycle(d);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
